// File: rtl/lzrw1_decompressor.sv
// LZRW1 decompressor: expands literal / copy items into a byte stream,
// keeping a circular history buffer that copy items read back from.
module lzrw1_decompressor #(
  parameter int HISTSIZE = 4096,
  parameter int CNTW     = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            tok_valid,
  output logic            tok_ready,
  input  logic            tok_copy,
  input  logic [7:0]      tok_byte0,
  input  logic [7:0]      tok_byte1,
  input  logic            tok_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [7:0]      out_byte,
  output logic [CNTW-1:0] byte_count,
  output logic            done,
  output logic            error
);

  localparam int AW = $clog2(HISTSIZE);
  localparam int FW = AW + 1;

  // DRAIN waits for the final byte of a tok_last item to leave the output register.
  typedef enum logic [2:0] {
    S_IDLE,
    S_COPY,
    S_DRAIN,
    S_DONE,
    S_ERROR
  } state_e;

  state_e          state_q, state_d;
  logic            out_valid_q, out_valid_d;
  logic [7:0]      out_byte_q, out_byte_d;
  logic [CNTW-1:0] byte_count_q, byte_count_d;
  logic            done_q, done_d;
  logic            error_q, error_d;
  logic [AW-1:0]   wp_q, wp_d;
  logic [FW-1:0]   fill_q, fill_d;
  logic [11:0]     off_q, off_d;
  logic [4:0]      remain_q, remain_d;
  logic            last_q, last_d;

  logic [7:0]      hist [HISTSIZE];
  logic [AW-1:0]   rd_addr;
  logic [7:0]      hist_rdata;
  logic            push;
  logic [7:0]      push_byte;
  logic            out_free;
  logic            xfer;
  logic            tok_accept;
  logic [11:0]     off_new;

  assign out_free   = !out_valid_q || out_ready;
  assign xfer       = out_valid_q && out_ready;
  assign tok_ready  = !reset && (state_q == S_IDLE) && out_free;
  assign tok_accept = tok_valid && tok_ready;
  assign off_new    = {tok_byte0[3:0], tok_byte1};
  assign rd_addr    = wp_q - AW'(off_q);
  assign hist_rdata = hist[rd_addr];

  // Next-state logic: item decode, copy expansion, output register and counters.
  always_comb begin
    // NOTE: every variable gets a default here so no path leaves it unassigned (no latches).
    state_d      = state_q;
    out_valid_d  = out_valid_q;
    out_byte_d   = out_byte_q;
    byte_count_d = byte_count_q;
    done_d       = done_q;
    error_d      = error_q;
    wp_d         = wp_q;
    fill_d       = fill_q;
    off_d        = off_q;
    remain_d     = remain_q;
    last_d       = last_q;
    push         = 1'b0;
    push_byte    = 8'h00;

    // A completed transfer frees the output register unless it is reloaded below.
    if (xfer) begin
      out_valid_d  = 1'b0;
      byte_count_d = byte_count_q + CNTW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (tok_accept) begin
          last_d = tok_last;
          if (!tok_copy) begin
            push      = 1'b1;
            push_byte = tok_byte0;
            if (tok_last) state_d = S_DRAIN;
          end else begin
            off_d    = off_new;
            remain_d = {1'b0, tok_byte0[7:4]} + 5'd1;
            // Offset must point at a byte that has actually been written.
            if (off_new == 12'd0 || FW'(off_new) > fill_q) begin
              error_d = 1'b1;
              state_d = S_ERROR;
            end else begin
              state_d = S_COPY;
            end
          end
        end
      end
      S_COPY: begin
        if (out_free) begin
          push      = 1'b1;
          push_byte = hist_rdata;
          remain_d  = remain_q - 5'd1;
          if (remain_q == 5'd1) state_d = last_q ? S_DRAIN : S_IDLE;
        end
      end
      S_DRAIN: begin
        if (xfer) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      default: ; // DONE and ERROR hold until reset
    endcase

    // Every emitted byte also enters the history at the write pointer.
    if (push) begin
      out_byte_d  = push_byte;
      out_valid_d = 1'b1;
      wp_d        = wp_q + AW'(1);
      fill_d      = (fill_q == FW'(HISTSIZE)) ? fill_q : fill_q + FW'(1);
    end
  end

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      state_q      <= S_IDLE;
      out_valid_q  <= 1'b0;
      out_byte_q   <= 8'h00;
      byte_count_q <= '0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      wp_q         <= '0;
      fill_q       <= '0;
      off_q        <= '0;
      remain_q     <= '0;
      last_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      out_byte_q   <= out_byte_d;
      byte_count_q <= byte_count_d;
      done_q       <= done_d;
      error_q      <= error_d;
      wp_q         <= wp_d;
      fill_q       <= fill_d;
      off_q        <= off_d;
      remain_q     <= remain_d;
      last_q       <= last_d;
    end
  end

  // History write; a byte written this cycle is visible to next cycle's read.
  always_ff @(posedge clock) begin
    // NOTE: the history array has no reset; fill_q guarantees no unwritten entry is read.
    if (push) hist[wp_q] <= push_byte;
  end

  assign out_valid  = out_valid_q;
  assign out_byte   = out_byte_q;
  assign byte_count = byte_count_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_lzrw1_decompressor.sv
// Self-checking bench for lzrw1_decompressor: directed table, random stream
// against an LZ reference model, and a reset-mid-copy sequence.
module tb_lzrw1_decompressor;

  localparam int HISTSIZE = 4096;
  localparam int CNTW     = 32;

  logic            clock = 1'b0;
  logic            reset;
  logic            tok_valid;
  logic            tok_ready;
  logic            tok_copy;
  logic [7:0]      tok_byte0;
  logic [7:0]      tok_byte1;
  logic            tok_last;
  logic            out_valid;
  logic            out_ready;
  logic [7:0]      out_byte;
  logic [CNTW-1:0] byte_count;
  logic            done;
  logic            error;

  always #5 clock = ~clock;

  lzrw1_decompressor #(.HISTSIZE(HISTSIZE), .CNTW(CNTW)) dut (
    .clock      (clock),
    .reset      (reset),
    .tok_valid  (tok_valid),
    .tok_ready  (tok_ready),
    .tok_copy   (tok_copy),
    .tok_byte0  (tok_byte0),
    .tok_byte1  (tok_byte1),
    .tok_last   (tok_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_byte   (out_byte),
    .byte_count (byte_count),
    .done       (done),
    .error      (error)
  );

  typedef struct packed {
    logic       copy;
    logic [7:0] b0;
    logic [7:0] b1;
    logic       last;
  } item_t;

  typedef struct {
    item_t      it [4];
    int         n;
    int         ready_mode;   // 0: always ready, 1: random
    int         hold_start;   // cycle at which out_ready is held low for 10 cycles, -1 none
    int         exp_count;
    logic [7:0] exp_first;
    logic [7:0] exp_final;
    bit         exp_error;
    bit         exp_done;
  } vec_t;

  item_t      items_q [$];
  logic [7:0] got_q [$];
  logic [7:0] exp_q [$];
  bit         exp_err;
  bit         exp_done;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic item_t mk(input logic c, input logic [7:0] b0, input logic [7:0] b1,
                               input logic l);
    item_t r;
    r.copy = c;
    r.b0   = b0;
    r.b1   = b1;
    r.last = l;
    return r;
  endfunction

  // Reference: output position p of a copy repeats output position p-off.
  task automatic model_expand();
    exp_q.delete();
    exp_err  = 1'b0;
    exp_done = 1'b0;
    foreach (items_q[i]) begin
      if (!items_q[i].copy) begin
        exp_q.push_back(items_q[i].b0);
      end else begin
        int len;
        int off;
        int avail;
        len   = int'(items_q[i].b0[7:4]) + 1;
        off   = int'({items_q[i].b0[3:0], items_q[i].b1});
        avail = (exp_q.size() < HISTSIZE) ? exp_q.size() : HISTSIZE;
        if (off == 0 || off > avail) begin
          exp_err = 1'b1;
          break;
        end
        for (int k = 0; k < len; k++) exp_q.push_back(exp_q[exp_q.size() - off]);
      end
      if (items_q[i].last) begin
        exp_done = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    tok_valid = 1'b0;
    tok_copy  = 1'b0;
    tok_byte0 = 8'h00;
    tok_byte1 = 8'h00;
    tok_last  = 1'b0;
    out_ready = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Drives items_q, collects transferred bytes into got_q, checks stall stability.
  task automatic run_stream(input int ready_mode, input int hold_start, input int abort_at,
                            input int max_cycles);
    int         idx;
    int         cyc;
    bit         fin;
    bit         stalled;
    bit         chk_done;
    bit         accepted;
    bit         xfer;
    logic [7:0] stall_byte;
    idx        = 0;
    cyc        = 0;
    fin        = 1'b0;
    stalled    = 1'b0;
    chk_done   = 1'b0;
    stall_byte = 8'h00;
    got_q.delete();
    while (!fin) begin
      @(negedge clock);
      if (chk_done) begin
        check("done_after_final", done, 1);
        chk_done = 1'b0;
      end
      if (idx < items_q.size()) begin
        tok_valid = 1'b1;
        tok_copy  = items_q[idx].copy;
        tok_byte0 = items_q[idx].b0;
        tok_byte1 = items_q[idx].b1;
        tok_last  = items_q[idx].last;
      end else begin
        tok_valid = 1'b0;
        tok_last  = 1'b0;
      end
      out_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (hold_start >= 0 && cyc >= hold_start && cyc < hold_start + 10) out_ready = 1'b0;
      #1;
      if (stalled) check("stall_stable", {out_valid, out_byte}, {1'b1, stall_byte});
      accepted = tok_valid && tok_ready;
      xfer     = out_valid && out_ready;
      if (xfer) begin
        got_q.push_back(out_byte);
        if (exp_done && got_q.size() == exp_q.size()) begin
          check("done_before_final", done, 0);
          chk_done = 1'b1;
        end
      end
      stalled    = out_valid && !out_ready;
      stall_byte = out_byte;
      if (accepted) idx++;
      cyc++;
      if (abort_at >= 0 && cyc >= abort_at) begin
        fin = 1'b1;
      end else if ((done || error) && !out_valid && !chk_done) begin
        fin = 1'b1;
      end else if (cyc >= max_cycles) begin
        n_cmp++;
        n_bad++;
        $display("FAIL cycle_budget: stream still running after %0d cycles", cyc);
        fin = 1'b1;
      end
    end
  endtask

  task automatic compare_bytes(input string tag);
    check({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({tag, "_byte"}, got_q[i], exp_q[i]);
  endtask

  vec_t tbl [6];

  initial begin
    // Directed vectors.
    tbl[0].it[0] = mk(0, 8'h41, 8'h00, 0);
    tbl[0].it[1] = mk(0, 8'h42, 8'h00, 0);
    tbl[0].it[2] = mk(0, 8'h43, 8'h00, 1);
    tbl[0].n = 3; tbl[0].ready_mode = 0; tbl[0].hold_start = -1; tbl[0].exp_count = 3;
    tbl[0].exp_first = 8'h41; tbl[0].exp_final = 8'h43; tbl[0].exp_error = 0; tbl[0].exp_done = 1;

    tbl[1].it[0] = mk(0, 8'h61, 8'h00, 0);
    tbl[1].it[1] = mk(0, 8'h62, 8'h00, 0);
    tbl[1].it[2] = mk(0, 8'h63, 8'h00, 0);
    tbl[1].it[3] = mk(1, 8'h20, 8'h03, 1);
    tbl[1].n = 4; tbl[1].ready_mode = 0; tbl[1].hold_start = -1; tbl[1].exp_count = 6;
    tbl[1].exp_first = 8'h61; tbl[1].exp_final = 8'h63; tbl[1].exp_error = 0; tbl[1].exp_done = 1;

    tbl[2].it[0] = mk(0, 8'h5A, 8'h00, 0);
    tbl[2].it[1] = mk(1, 8'hF0, 8'h01, 1);
    tbl[2].n = 2; tbl[2].ready_mode = 0; tbl[2].hold_start = -1; tbl[2].exp_count = 17;
    tbl[2].exp_first = 8'h5A; tbl[2].exp_final = 8'h5A; tbl[2].exp_error = 0; tbl[2].exp_done = 1;

    tbl[3].it[0] = mk(0, 8'hAA, 8'h00, 0);
    tbl[3].it[1] = mk(0, 8'hBB, 8'h00, 0);
    tbl[3].it[2] = mk(1, 8'h00, 8'h05, 1);
    tbl[3].n = 3; tbl[3].ready_mode = 0; tbl[3].hold_start = -1; tbl[3].exp_count = 2;
    tbl[3].exp_first = 8'hAA; tbl[3].exp_final = 8'hBB; tbl[3].exp_error = 1; tbl[3].exp_done = 0;

    tbl[4].it[0] = mk(1, 8'h30, 8'h00, 1);
    tbl[4].n = 1; tbl[4].ready_mode = 0; tbl[4].hold_start = -1; tbl[4].exp_count = 0;
    tbl[4].exp_first = 8'h00; tbl[4].exp_final = 8'h00; tbl[4].exp_error = 1; tbl[4].exp_done = 0;

    tbl[5] = tbl[1];
    tbl[5].ready_mode = 1; tbl[5].hold_start = 5;

    // Reset state.
    reset     = 1'b1;
    tok_valid = 1'b0;
    tok_copy  = 1'b0;
    tok_byte0 = 8'h00;
    tok_byte1 = 8'h00;
    tok_last  = 1'b0;
    out_ready = 1'b0;
    #2;
    check("rst_tok_ready", tok_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_byte", out_byte, 0);
    check("rst_byte_count", byte_count, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("idle_tok_ready", tok_ready, 1);

    // Table-driven directed scenarios.
    for (int v = 0; v < 6; v++) begin
      do_reset();
      items_q.delete();
      for (int j = 0; j < tbl[v].n; j++) items_q.push_back(tbl[v].it[j]);
      model_expand();
      run_stream(tbl[v].ready_mode, tbl[v].hold_start, -1, 500);
      @(negedge clock);
      #1;
      compare_bytes($sformatf("vec%0d", v));
      check($sformatf("vec%0d_count", v), byte_count, tbl[v].exp_count);
      check($sformatf("vec%0d_error", v), error, tbl[v].exp_error);
      check($sformatf("vec%0d_done", v), done, tbl[v].exp_done);
      if (tbl[v].exp_count > 0 && got_q.size() > 0) begin
        check($sformatf("vec%0d_first", v), got_q[0], tbl[v].exp_first);
        check($sformatf("vec%0d_final", v), got_q[got_q.size() - 1], tbl[v].exp_final);
      end
      if (tbl[v].exp_error) begin
        tok_valid = 1'b1;
        tok_copy  = 1'b0;
        tok_byte0 = 8'h77;
        tok_last  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
          @(negedge clock);
          #1;
          check($sformatf("vec%0d_err_tok_ready", v), tok_ready, 0);
          check($sformatf("vec%0d_err_out_valid", v), out_valid, 0);
        end
        check($sformatf("vec%0d_err_count_hold", v), byte_count, tbl[v].exp_count);
        tok_valid = 1'b0;
      end
    end

    // Random stream long enough to wrap the history and saturate the fill count.
    do_reset();
    items_q.delete();
    begin
      int emitted;
      int lim;
      int len;
      int off;
      emitted = 0;
      for (int i = 0; i < 900; i++) begin
        bit is_last;
        is_last = (i == 899);
        if (emitted == 0 || $urandom_range(0, 2) == 0) begin
          items_q.push_back(mk(0, 8'($urandom), 8'($urandom), is_last));
          emitted++;
        end else begin
          lim = (emitted < 4095) ? emitted : 4095;
          len = $urandom_range(0, 15);
          if ($urandom_range(0, 7) == 0) off = $urandom_range(1, (lim < 3) ? lim : 3);
          else off = $urandom_range(1, lim);
          items_q.push_back(mk(1, {4'(len), 4'(off >> 8)}, 8'(off), is_last));
          emitted += len + 1;
        end
      end
    end
    model_expand();
    run_stream(1, -1, -1, 60000);
    @(negedge clock);
    #1;
    compare_bytes("rand");
    check("rand_count", byte_count, exp_q.size());
    check("rand_done", done, 1);
    check("rand_error", error, 0);
    check("rand_tok_ready_done", tok_ready, 0);

    // Reset asserted in the middle of a long copy.
    do_reset();
    items_q.delete();
    items_q.push_back(mk(0, 8'h5A, 8'h00, 0));
    items_q.push_back(mk(1, 8'hF0, 8'h01, 1));
    model_expand();
    run_stream(0, -1, 6, 100);
    check("mid_partial_len", got_q.size() > 0 && got_q.size() < 17, 1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_byte_count", byte_count, 0);
    check("mid_rst_error", error, 0);
    check("mid_rst_done", done, 0);
    @(negedge clock);
    reset = 1'b0;
    items_q.delete();
    items_q.push_back(mk(0, 8'h11, 8'h00, 1));
    model_expand();
    run_stream(0, -1, -1, 100);
    @(negedge clock);
    #1;
    compare_bytes("post_rst");
    check("post_rst_byte", (got_q.size() > 0) ? got_q[0] : 8'h00, 8'h11);
    check("post_rst_count", byte_count, 1);
    check("post_rst_done", done, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
